sklansky_pipe_adder: RTL and testbench
======================================

// Module: sklansky_pipe_adder
// PURPOSE
//  - Parametrised, pipelined Sklansky parallel-prefix adder: WIDTH-bit a + b + cin -> sum, cout.
//  - Configurable register insertion between prefix levels, valid/ready handshake with full
//    backpressure, and a TAG sideband carried alongside each operand pair.
//  - Successor to the fixed 16-bit combinational Sklansky adder; used in datapaths that need
//    wide adds at high clock rates.
// PARAMETERS
//  - WIDTH      32  operand width; power of 2, 4..128; LEVELS = log2(WIDTH)
//  - REG_EVERY  2   prefix levels per pipeline segment; 1..LEVELS
//  - TAG_W      4   sideband tag width, >=1, passed through unmodified
// PORTS
//  - clk        in   1        clock, all flops rising edge
//  - rst_n      in   1        asynchronous active-low reset
//  - in_valid   in   1        operand pair present
//  - in_ready   out  1        adder can accept this cycle
//  - in_a       in   WIDTH    operand a
//  - in_b       in   WIDTH    operand b
//  - in_cin     in   1        carry in
//  - in_tag     in   TAG_W    sideband tag
//  - out_valid  out  1        result present
//  - out_ready  in   1        consumer accepts result
//  - out_sum    out  WIDTH    (a+b+cin) mod 2^WIDTH
//  - out_cout   out  1        carry out of bit WIDTH-1
//  - out_tag    out  TAG_W    tag of the operand pair producing this result
//  - out_ovf    out  1        signed overflow (only with SKLANSKY_OVF_EN)
// BEHAVIOUR
//  - NSEG = ceil(LEVELS/REG_EVERY); NSTG = 1 + NSEG register stages; latency = NSTG cycles
//    from input handshake to out_valid with no stall (WIDTH=32, REG_EVERY=2 -> 4).
//  - Stage 0 registers bitwise g=a&b, p=a^b, cin, tag. Segment k applies Sklansky levels
//    [k*REG_EVERY, min((k+1)*REG_EVERY,LEVELS)) then registers; last segment also forms
//    sum[i] = p[i] ^ G[i-1:-1] (cin is position -1) and cout = G[WIDTH-1:-1].
//  - Cin folds in as generate at position -1 (grey cells on the cin-reaching prefixes);
//    propagate spans are kept only where a later level needs them.
//  - Handshake per stage s: adv[s] = !v[s] | adv[s+1]; adv[NSTG] = out_ready.
//    in_ready = adv[0]; out_valid = v[NSTG-1]. Bubbles collapse; stalled stages hold data.
//  - Transfer on in_valid & in_ready; out beat retires on out_valid & out_ready.
//  - Full pipeline + out_ready=0: in_ready=0, all data held stable; throughput 1/cycle when
//    out_ready held high.
//  - Simultaneous retire and accept when full: both occur, occupancy unchanged.
//  - Reset (any time, incl. mid-operation): all v[s]=0, all data regs 0; out_valid=0,
//    out_sum=0, out_cout=0, out_tag=0, out_ovf=0; in_ready=1 from first cycle after release.
//    In-flight operands discarded.
//  - out_* hold stable while out_valid & !out_ready; no combinational in->out path.
// CONFIGURATION
//  - SKLANSKY_OVF_EN defined: out_ovf = cout_into_msb ^ cout (signed overflow), registered and
//    piped in step with out_sum; msb carry taken as G[WIDTH-2:-1].
//  - Not defined: out_ovf port absent; no extra flops.
// STRUCTURE
//  - Package sklansky_pkg: gp_t struct {g,p}; function clog2; function seg_last_level(k,RE).
//  - Sub-module sklansky_level #(WIDTH, LVL): one combinational prefix level over gp_t[WIDTH+1]
//    (index 0 = cin); black cells where span >= 0 stays open, grey cells once span reaches cin.
//  - Top: generate loop over segments instantiating sklansky_level, plus stage regs/handshake.
// TESTING
//  - WIDTH=32: a=FFFF_FFFF, b=0, cin=1 -> sum=0, cout=1, out_valid exactly 4 cycles later.
//  - Stream 1000 random a,b,cin with tags 0..15 cycling, out_ready=1 -> one result/cycle,
//    matches a+b+cin, tags in order.
//  - Fill pipe with out_ready=0 -> in_ready falls after NSTG accepts; out_sum stable; release
//    -> no loss, no duplication.
//  - Random in_valid/out_ready toggling (50%) for 5000 cycles -> scoreboard order/value clean.
//  - Assert rst_n low with 3 beats in flight -> all outputs 0 next edge; no stale beat after.
//  - OVF_EN: a=7FFF_FFFF, b=1, cin=0 -> out_ovf=1, cout=0; a=8000_0000, b=8000_0000 -> ovf=1,
//    cout=1, sum=0. Repeat sweeps for WIDTH=8/64, REG_EVERY=1 and =LEVELS.

Source files
------------

// File: rtl/sklansky_pkg.sv
// Shared types and elaboration helpers for the pipelined Sklansky adder.
// gp_t carries one (generate, propagate) pair per prefix position.
package sklansky_pkg;

  typedef struct packed {
    logic g;
    logic p;
  } gp_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Last prefix level (0-based) covered by segment k when each segment spans re levels.
  function automatic int seg_last_level(input int k, input int re);
    return (k + 1) * re - 1;
  endfunction

endpackage

// File: rtl/sklansky_level.sv
// One combinational Sklansky prefix level over WIDTH+1 positions (index 0 is carry-in).
// Grey cells keep only the group generate once a span reaches carry-in.
module sklansky_level
  import sklansky_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int LVL   = 0
) (
  input  gp_t [WIDTH:0] x,
  output gp_t [WIDTH:0] y
);

  for (genvar j = 0; j <= WIDTH; j++) begin : g_cell
    if (((j >> LVL) & 1) == 0) begin : g_pass
      assign y[j] = x[j];
    end else begin : g_op
      localparam int SRC = ((j >> LVL) << LVL) - 1;
      if (j < (2 << LVL)) begin : g_grey
        assign y[j] = gp_t'{g: x[j].g | (x[j].p & x[SRC].g), p: 1'b0};
      end else begin : g_black
        assign y[j] = gp_t'{g: x[j].g | (x[j].p & x[SRC].g), p: x[j].p & x[SRC].p};
      end
    end
  end

endmodule

// File: rtl/sklansky_pipe_adder.sv
// Pipelined Sklansky adder with valid/ready backpressure and a tag sideband.
// Define SKLANSKY_OVF_EN to add the registered signed-overflow output out_ovf.
module sklansky_pipe_adder
  import sklansky_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int REG_EVERY = 2,
  parameter int TAG_W     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic [TAG_W-1:0] out_tag
`ifdef SKLANSKY_OVF_EN
  ,
  output logic             out_ovf
`endif
);

  localparam int LEVELS = clog2(WIDTH);
  localparam int NSEG   = (LEVELS + REG_EVERY - 1) / REG_EVERY;
  localparam int NSTG   = NSEG + 1;

  logic [NSTG-1:0]  v;
  logic [NSTG-1:0]  adv;
  logic             run;
  gp_t  [WIDTH:0]   gp_in;
  gp_t  [WIDTH:0]   st_gp  [NSEG];
  logic [WIDTH-1:0] st_p0  [NSEG];
  logic [TAG_W-1:0] st_tag [NSEG];
  gp_t  [WIDTH:0]   net    [LEVELS];
  logic [WIDTH-1:0] sum_c;
  logic             cout_c;
  logic             unused_bits;

  always_comb begin
    gp_in[0] = gp_t'{g: in_cin, p: 1'b0};
    for (int i = 0; i < WIDTH; i++) begin
      gp_in[i+1] = gp_t'{g: in_a[i] & in_b[i], p: in_a[i] ^ in_b[i]};
    end
  end

  // A stage may load when it is empty or everything downstream of it is moving.
  always_comb begin
    run = 1'b1;
    adv = '0;
    for (int s = NSTG - 1; s >= 0; s--) begin
      run    = run & v[s];
      adv[s] = out_ready | ~run;
    end
  end

  assign in_ready  = adv[0];
  assign out_valid = v[NSTG-1];

  for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
    gp_t [WIDTH:0] lin;
    if (l % REG_EVERY == 0) begin : g_start
      assign lin = st_gp[l / REG_EVERY];
    end else begin : g_chain
      assign lin = net[l - 1];
    end
    sklansky_level #(.WIDTH(WIDTH), .LVL(l)) u_level (
      .x(lin),
      .y(net[l])
    );
  end

  // Top position still holds bit WIDTH-1's own g/p; one more grey cell yields cout.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      sum_c[i] = st_p0[NSEG-1][i] ^ net[LEVELS-1][i].g;
    end
    cout_c = net[LEVELS-1][WIDTH].g | (net[LEVELS-1][WIDTH].p & net[LEVELS-1][WIDTH-1].g);
  end

  assign unused_bits = ^net[LEVELS-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v        <= '0;
      st_gp    <= '{default: '0};
      st_p0    <= '{default: '0};
      st_tag   <= '{default: '0};
      out_sum  <= '0;
      out_cout <= 1'b0;
      out_tag  <= '0;
`ifdef SKLANSKY_OVF_EN
      out_ovf  <= 1'b0;
`endif
    end else begin
      if (adv[0]) begin
        v[0] <= in_valid;
        if (in_valid) begin
          st_gp[0]  <= gp_in;
          st_p0[0]  <= in_a ^ in_b;
          st_tag[0] <= in_tag;
        end
      end
      for (int s = 1; s < NSEG; s++) begin
        if (adv[s]) begin
          v[s] <= v[s-1];
          if (v[s-1]) begin
            st_gp[s]  <= net[seg_last_level(s - 1, REG_EVERY)];
            st_p0[s]  <= st_p0[s-1];
            st_tag[s] <= st_tag[s-1];
          end
        end
      end
      if (adv[NSTG-1]) begin
        v[NSTG-1] <= v[NSTG-2];
        if (v[NSTG-2]) begin
          out_sum  <= sum_c;
          out_cout <= cout_c;
          out_tag  <= st_tag[NSEG-1];
`ifdef SKLANSKY_OVF_EN
          out_ovf  <= net[LEVELS-1][WIDTH-1].g ^ cout_c;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_sklansky_pipe_adder.sv
// Self-checking bench for sklansky_pipe_adder: vector table, streaming, backpressure and reset.
// Expected results are queued at input handshake and compared when each beat retires.
module tb_sklansky_pipe_adder;

  localparam int WIDTH     = 32;
  localparam int REG_EVERY = 2;
  localparam int TAG_W     = 4;
  localparam int LEVELS    = $clog2(WIDTH);
  localparam int NSEG      = (LEVELS + REG_EVERY - 1) / REG_EVERY;
  localparam int NSTG      = NSEG + 1;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic [TAG_W-1:0] out_tag;
`ifdef SKLANSKY_OVF_EN
  logic             out_ovf;
`endif

  typedef struct {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic [TAG_W-1:0] tag;
  } exp_t;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [TAG_W-1:0] tag;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
  } vec_t;

  exp_t             sb[$];
  exp_t             cur_exp;
  vec_t             vecs[9];
  int               checks;
  int               errors;
  int               retired;
  int               stalls;
  bit               count_stalls;
  bit               rand_ready;
  bit               hold_valid;
  logic [WIDTH-1:0] hold_sum;
  logic             hold_cout;
  logic [TAG_W-1:0] hold_tag;

  sklansky_pipe_adder #(.WIDTH(WIDTH), .REG_EVERY(REG_EVERY), .TAG_W(TAG_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_cin   (in_cin),
    .in_tag   (in_tag),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .out_cout (out_cout),
    .out_tag  (out_tag)
`ifdef SKLANSKY_OVF_EN
    ,
    .out_ovf  (out_ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic cin, input logic [TAG_W-1:0] tag);
    exp_t r;
    logic [WIDTH:0] t;
    t      = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    r.sum  = t[WIDTH-1:0];
    r.cout = t[WIDTH];
    r.ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (t[WIDTH-1] != a[WIDTH-1]);
    r.tag  = tag;
    return r;
  endfunction

  // Hold one beat on the inputs until the DUT accepts it (bounded).
  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input logic cin, input logic [TAG_W-1:0] tag, input exp_t e);
    bit ok;
    ok       = 1'b0;
    in_a     = a;
    in_b     = b;
    in_cin   = cin;
    in_tag   = tag;
    cur_exp  = e;
    in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checkOutput("accept", 64'(ok), 64'd1);
  endtask

  task automatic sendRandom(input logic [TAG_W-1:0] tag);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c;
    a = WIDTH'($urandom);
    b = WIDTH'($urandom);
    c = 1'($urandom_range(0, 1));
    applyStimulus(a, b, c, tag, model(a, b, c, tag));
  endtask

  task automatic waitDrain();
    for (int i = 0; i < 300 && sb.size() != 0; i++) @(posedge clk);
    #1;
    checkOutput("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  // Scoreboard retire, hold-stability and accept tracking, all sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_valid = 1'b0;
    end else begin
      if (hold_valid && out_valid) begin
        checkOutput("hold_sum", 64'(out_sum), 64'(hold_sum));
        checkOutput("hold_cout", 64'(out_cout), 64'(hold_cout));
        checkOutput("hold_tag", 64'(out_tag), 64'(hold_tag));
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checkOutput("spurious_beat", 64'(out_valid), 64'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          checkOutput("sum", 64'(out_sum), 64'(e.sum));
          checkOutput("cout", 64'(out_cout), 64'(e.cout));
          checkOutput("tag", 64'(out_tag), 64'(e.tag));
`ifdef SKLANSKY_OVF_EN
          checkOutput("ovf", 64'(out_ovf), 64'(e.ovf));
`endif
          retired++;
        end
      end
      hold_valid = out_valid && !out_ready;
      hold_sum   = out_sum;
      hold_cout  = out_cout;
      hold_tag   = out_tag;
      if (in_valid && in_ready) sb.push_back(cur_exp);
      if (count_stalls && in_valid && !in_ready) stalls++;
    end
  end

  always @(posedge clk) begin
    if (rand_ready) begin
      #1;
      out_ready = ($urandom_range(0, 1) == 1);
    end
  end

  initial begin
    #5_000_000;
    errors++;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    int lat;
    int acc;
    int base;
    int post_valid;

    vecs[0] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 4'd0, 32'h0000_0000, 1'b1, 1'b0};
    vecs[1] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 4'd1, 32'h8000_0000, 1'b0, 1'b1};
    vecs[2] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 4'd2, 32'h0000_0000, 1'b1, 1'b1};
    vecs[3] = '{32'h1234_5678, 32'h8765_4321, 1'b0, 4'd3, 32'h9999_9999, 1'b0, 1'b0};
    vecs[4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 4'd4, 32'hFFFF_FFFF, 1'b1, 1'b0};
    vecs[5] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 4'd5, 32'h0000_0000, 1'b0, 1'b0};
    vecs[6] = '{32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 4'd6, 32'h0000_0000, 1'b1, 1'b0};
    vecs[7] = '{32'hDEAD_BEEF, 32'h0123_4567, 1'b0, 4'd7, 32'hDFD1_0456, 1'b0, 1'b0};
    vecs[8] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, 4'd8, 32'hFFFF_FFFF, 1'b0, 1'b1};

    checks       = 0;
    errors       = 0;
    retired      = 0;
    stalls       = 0;
    count_stalls = 1'b0;
    rand_ready   = 1'b0;
    hold_valid   = 1'b0;
    rst_n        = 1'b0;
    in_valid     = 1'b0;
    in_a         = '0;
    in_b         = '0;
    in_cin       = 1'b0;
    in_tag       = '0;
    out_ready    = 1'b1;

    #12;
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_out_sum", 64'(out_sum), 64'd0);
    checkOutput("rst_out_cout", 64'(out_cout), 64'd0);
    checkOutput("rst_out_tag", 64'(out_tag), 64'd0);
`ifdef SKLANSKY_OVF_EN
    checkOutput("rst_out_ovf", 64'(out_ovf), 64'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("rst_in_ready", 64'(in_ready), 64'd1);

    $display("[TB] latency check");
    in_a     = 32'hFFFF_FFFF;
    in_b     = 32'h0;
    in_cin   = 1'b1;
    in_tag   = 4'd5;
    cur_exp  = '{sum: 32'h0, cout: 1'b1, ovf: 1'b0, tag: 4'd5};
    in_valid = 1'b1;
    lat      = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      lat++;
      if (out_valid) break;
    end
    checkOutput("latency", 64'(lat), 64'(NSTG));
    waitDrain();

    $display("[TB] vector table");
    for (int i = 0; i < 9; i++) begin
      exp_t e;
      e = '{sum: vecs[i].sum, cout: vecs[i].cout, ovf: vecs[i].ovf, tag: vecs[i].tag};
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].tag, e);
    end
    waitDrain();

    $display("[TB] stream 1000 beats");
    base         = retired;
    count_stalls = 1'b1;
    for (int n = 0; n < 1000; n++) sendRandom(TAG_W'(n));
    count_stalls = 1'b0;
    waitDrain();
    checkOutput("stream_stalls", 64'(stalls), 64'd0);
    checkOutput("stream_retired", 64'(retired - base), 64'd1000);

    $display("[TB] fill with backpressure");
    out_ready = 1'b0;
    acc       = 0;
    for (int i = 0; i < 20; i++) begin
      in_a     = WIDTH'($urandom);
      in_b     = WIDTH'($urandom);
      in_cin   = 1'($urandom_range(0, 1));
      in_tag   = TAG_W'(i);
      cur_exp  = model(in_a, in_b, in_cin, in_tag);
      in_valid = 1'b1;
      @(negedge clk);
      if (!in_ready) break;
      acc++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    checkOutput("fill_accepts", 64'(acc), 64'(NSTG));
    repeat (5) @(posedge clk);
    #1;
    checkOutput("full_in_ready", 64'(in_ready), 64'd0);
    checkOutput("full_out_valid", 64'(out_valid), 64'd1);
    base      = retired;
    out_ready = 1'b1;
    waitDrain();
    checkOutput("fill_retired", 64'(retired - base), 64'(acc));

    $display("[TB] random valid/ready toggling");
    base       = retired;
    rand_ready = 1'b1;
    for (int n = 0; n < 2500; n++) begin
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clk);
        #1;
      end
      sendRandom(TAG_W'(n));
    end
    rand_ready = 1'b0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    waitDrain();
    checkOutput("random_retired", 64'(retired - base), 64'd2500);

    $display("[TB] reset with beats in flight");
    out_ready = 1'b0;
    for (int n = 0; n < 3; n++) sendRandom(TAG_W'(n + 9));
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    sb.delete();
    @(posedge clk);
    #1;
    checkOutput("midrst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("midrst_out_sum", 64'(out_sum), 64'd0);
    checkOutput("midrst_out_cout", 64'(out_cout), 64'd0);
    checkOutput("midrst_out_tag", 64'(out_tag), 64'd0);
    checkOutput("midrst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst_n      = 1'b1;
    out_ready  = 1'b1;
    post_valid = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) post_valid++;
    end
    checkOutput("post_rst_stale", 64'(post_valid), 64'd0);
    @(posedge clk);
    #1;
    applyStimulus(vecs[7].a, vecs[7].b, vecs[7].cin, vecs[7].tag,
                  '{sum: vecs[7].sum, cout: vecs[7].cout, ovf: vecs[7].ovf, tag: vecs[7].tag});
    waitDrain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
